mda_motor_pwm_gen: RTL and testbench
====================================

MDA_MOTOR_PWM_GEN -- requirements
Module: mda_motor_pwm_gen

Interface
REQ-001 SHALL have parameter PERIOD, default 1000: PWM period in clk cycles, range 2..1023.
REQ-002 SHALL have parameter REV_GAP, default 1024: forced-off cycles on a drive-direction reversal, range 1..4095.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port enable  input  1  global drive enable (kill switch).
REQ-006 SHALL have port cmd_duty  input  10  requested on-time per period, in cycles (magnitude).
REQ-007 SHALL have port cmd_dir  input  1  requested direction.
REQ-008 SHALL have port cmd_valid  input  1  command valid.
REQ-009 SHALL have port cmd_ready  output  1  command slot free.
REQ-010 SHALL have port dir  output  1  direction to the H-bridge controller.
REQ-011 SHALL have port on  output  1  PWM drive to the H-bridge controller.
REQ-012 SHALL have port period_start  output  1  one-cycle pulse at each period start.
REQ-013 SHALL have port reversing  output  1  high while in the REV state.

Function
REQ-014 SHALL run free period counter cnt 0..PERIOD-1; wraps to 0 after PERIOD-1; counts in all states, including while enable=0.
REQ-015 SHALL accept a command on a cycle with cmd_valid=1 and cmd_ready=1, storing {cmd_dir, cmd_duty} in a one-deep pending register.
REQ-016 SHALL drive cmd_ready = !pending_valid && state!=REV (combinational).
REQ-017 SHALL clamp applied duty to PERIOD when cmd_duty > PERIOD (100% on).
REQ-018 SHALL apply pending only at boundary (cycle where cnt==PERIOD-1); new values take effect from cnt==0; pending_valid clears on apply.
REQ-019 SHALL hold a command accepted on the boundary cycle itself in pending until the next boundary.
REQ-020 SHALL use states IDLE (active duty 0), RUN (active duty>0), REV (reversal gap).
REQ-021 SHALL on apply: if state==RUN and pending dir != dir -> REV; else dir<=pending dir, duty<=pending duty, state RUN if duty>0 else IDLE.
REQ-022 SHALL in REV hold on=0 and the old dir for exactly REV_GAP cycles; then update dir and duty, with state RUN/IDLE per duty.
REQ-023 SHALL make the new duty from REV effective at the next cnt==0.
REQ-024 SHALL compute on as registered: on(t+1) = enable && state==RUN && cnt(t) < active_duty.
REQ-025 SHALL give exactly active_duty on-cycles per period, the first one cycle after cnt==0.
REQ-026 SHALL change dir only in a cycle where on is 0, and on stays 0 in the following cycle.
REQ-027 SHALL register period_start, high for one cycle following each cnt==0 cycle.
REQ-028 SHALL on enable=0: next cycle on=0, state IDLE, active duty 0, REV aborted, dir unchanged.
REQ-029 SHALL accept commands while enable=0 and apply them at boundaries; on stays 0 until enable=1.
REQ-030 SHALL produce no REV when a zero-duty command is in force (IDLE); direction changes from IDLE directly.

Reset
REQ-031 SHALL on reset_n=0 asynchronously force cnt=0, state IDLE, pending empty, dir=0, on=0, period_start=0, reversing=0, active duty 0.
REQ-032 SHALL after reset release give cmd_ready=1, and the first period_start one cycle after the first cnt==0 clocked cycle.
REQ-033 SHALL on reset mid-REV or mid-period discard all state; no on pulse until a new command is applied.

Verification (PERIOD=8, REV_GAP=4)
REQ-034 SHALL cover: reset, enable=1, send duty=3 dir=1 -> from the next period, on high 3 of every 8 cycles, dir=1; period_start every 8 cycles.
REQ-035 SHALL cover: duty=12 -> on continuously high (clamped to 8); then duty=0 -> on low from the next period, state IDLE.
REQ-036 SHALL cover: RUN duty=5 dir=0, send dir=1 duty=5 -> at the boundary reversing=1, on=0 for 4 cycles with dir=0; then dir=1; 5-cycle pulses from the following cnt==0.
REQ-037 SHALL cover: two commands back-to-back -> second stalls (cmd_ready=0) until the first is applied; a command accepted when cnt==7 takes effect one period later.
REQ-038 SHALL cover: enable deasserted mid-pulse -> on=0 next cycle; reassert with a new command -> output resumes at the next boundary.
REQ-039 SHALL cover: reset_n asserted mid-REV -> all outputs 0 immediately (asynchronous), cmd_ready=1 after release.

Source files
------------

// File: rtl/mda_motor_pwm_gen_if.sv
// rtl/mda_motor_pwm_gen_if.sv - command handshake bundle for the motor PWM generator
interface mda_motor_pwm_gen_if;
  logic [9:0] cmd_duty;
  logic       cmd_dir;
  logic       cmd_valid;
  logic       cmd_ready;

  modport master (output cmd_duty, output cmd_dir, output cmd_valid, input cmd_ready);
  modport slave  (input cmd_duty, input cmd_dir, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/mda_motor_pwm_gen.sv
// rtl/mda_motor_pwm_gen.sv - H-bridge PWM generator with boundary-aligned commands and reversal gap
module mda_motor_pwm_gen #(
  parameter int PERIOD  = 1000,
  parameter int REV_GAP = 1024
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  mda_motor_pwm_gen_if.slave        cmd,
  output logic                      dir,
  output logic                      on,
  output logic                      period_start,
  output logic                      reversing
);
  typedef enum logic [1:0] {IDLE, RUN, REV} state_t;

  localparam logic [9:0]  LAST     = 10'(PERIOD - 1);
  localparam logic [9:0]  FULL     = 10'(PERIOD);
  localparam logic [11:0] GAP_LAST = 12'(REV_GAP - 1);

  state_t      state, state_nx;
  logic [9:0]  cnt;
  logic [9:0]  active_duty, duty_nx;
  logic [9:0]  pend_duty;
  logic        pend_dir, pend_valid;
  logic        dir_nx;
  logic [11:0] gap, gap_nx;
  logic        wait_zero, wait_zero_nx;
  logic        boundary, accept, apply;

  assign boundary      = (cnt == LAST);
  assign cmd.cmd_ready = !pend_valid && (state != REV);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign apply         = boundary && pend_valid;
  assign reversing     = (state == REV);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      cnt <= boundary ? 10'd0 : cnt + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
      pend_dir   <= 1'b0;
      pend_duty  <= '0;
    end else if (accept) begin
      pend_valid <= 1'b1;
      pend_dir   <= cmd.cmd_dir;
      pend_duty  <= (cmd.cmd_duty > FULL) ? FULL : cmd.cmd_duty;
    end else if (apply) begin
      pend_valid <= 1'b0;
    end
  end

  // The pending register stays frozen through REV (cmd_ready is low), so it
  // still holds the reversal target when the gap expires.
  always_comb begin
    state_nx     = state;
    dir_nx       = dir;
    duty_nx      = active_duty;
    gap_nx       = gap;
    wait_zero_nx = boundary ? 1'b0 : wait_zero;
    if (!enable) begin
      state_nx     = IDLE;
      duty_nx      = '0;
      wait_zero_nx = 1'b0;
      if (apply) dir_nx = pend_dir;
    end else if (state == REV) begin
      if (gap == 12'd0) begin
        dir_nx       = pend_dir;
        duty_nx      = pend_duty;
        state_nx     = (pend_duty != 10'd0) ? RUN : IDLE;
        // Post-reversal duty must wait for the next period start.
        wait_zero_nx = !boundary;
      end else begin
        gap_nx = gap - 12'd1;
      end
    end else if (apply) begin
      if (state == RUN && pend_dir != dir) begin
        state_nx = REV;
        gap_nx   = GAP_LAST;
      end else begin
        dir_nx   = pend_dir;
        duty_nx  = pend_duty;
        state_nx = (pend_duty != 10'd0) ? RUN : IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      dir          <= 1'b0;
      active_duty  <= '0;
      gap          <= '0;
      wait_zero    <= 1'b0;
      on           <= 1'b0;
      period_start <= 1'b0;
    end else begin
      state        <= state_nx;
      dir          <= dir_nx;
      active_duty  <= duty_nx;
      gap          <= gap_nx;
      wait_zero    <= wait_zero_nx;
      on           <= enable && (state == RUN) && !wait_zero && (cnt < active_duty);
      period_start <= (cnt == 10'd0);
    end
  end
endmodule

// File: tb/tb_mda_motor_pwm_gen.sv
// tb/tb_mda_motor_pwm_gen.sv - randomized and directed bench against a timestamp-based reference model
module tb_mda_motor_pwm_gen;
  localparam int P = 8;
  localparam int G = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_REV  = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic dir, on, period_start, reversing;

  mda_motor_pwm_gen_if bus ();

  mda_motor_pwm_gen #(.PERIOD(P), .REV_GAP(G)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .cmd          (bus),
    .dir          (dir),
    .on           (on),
    .period_start (period_start),
    .reversing    (reversing)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

  // Model: t counts clocked cycles since reset release, so cnt == t % P.
  longint t;
  int     mode;
  bit     m_dir;
  int     m_duty;
  longint rev_end;
  longint run_from;
  bit     rev_dir;
  int     rev_duty;
  bit     e_on, e_ps;
  bit     pq_dir[$];
  int     pq_duty[$];
  bit     m_accepted;

  function automatic bit m_ready();
    return (pq_dir.size() == 0) && (mode != M_REV);
  endfunction

  function automatic logic [4:0] exp_vec();
    return {e_on, m_dir, e_ps, (mode == M_REV), m_ready()};
  endfunction

  function automatic logic [4:0] obs();
    return {on, dir, period_start, reversing, bus.cmd_ready};
  endfunction

  task automatic model_reset();
    t = 0; mode = M_IDLE; m_dir = 0; m_duty = 0;
    rev_end = 0; run_from = 0; rev_dir = 0; rev_duty = 0;
    e_on = 0; e_ps = 0; m_accepted = 0;
    pq_dir.delete(); pq_duty.delete();
  endtask

  task automatic model_step(input bit en, input bit vld, input bit vdir, input int vduty);
    int c; bit rdy; bit ap; bit d; int u;
    c   = int'(t % P);
    rdy = m_ready();
    ap  = (c == P - 1) && (pq_dir.size() > 0);
    d   = 0; u = 0;
    e_on = en && (mode == M_RUN) && (t >= run_from) && (c < m_duty);
    e_ps = (c == 0);
    if (ap) begin d = pq_dir.pop_front(); u = pq_duty.pop_front(); end
    if (!en) begin
      mode = M_IDLE; m_duty = 0;
      if (ap) m_dir = d;
    end else if (mode == M_REV) begin
      if (t == rev_end) begin
        m_dir = rev_dir; m_duty = rev_duty;
        mode = (rev_duty > 0) ? M_RUN : M_IDLE;
        run_from = t - c + P;
      end
    end else if (ap) begin
      if (mode == M_RUN && d != m_dir) begin
        mode = M_REV; rev_end = t + G; rev_dir = d; rev_duty = u;
      end else begin
        m_dir = d; m_duty = u; mode = (u > 0) ? M_RUN : M_IDLE;
      end
    end
    if (vld && rdy) begin
      pq_dir.push_back(vdir);
      pq_duty.push_back((vduty > P) ? P : vduty);
      m_accepted = 1;
    end
    t++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(enable, bus.cmd_valid, bus.cmd_dir, int'(bus.cmd_duty));
    #1;
  endtask

  task automatic drive_cmd(input bit d, input int u);
    bus.cmd_valid = 1'b1; bus.cmd_dir = d; bus.cmd_duty = 10'(u);
    m_accepted = 0;
    for (int i = 0; i < 64 && !m_accepted; i++) tick();
    bus.cmd_valid = 1'b0;
    if (!m_accepted) begin
      total++;
      $display("FAIL cmd_accept_timeout dir=%0d duty=%0d not taken within 64 cycles", d, u);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_dir = 1'b0; bus.cmd_duty = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs() !== 5'b00001) $display("FAIL reset_state got %b want 00001", obs()); else pass_cnt++;
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < P + 2; i++) begin
      tick();
      if (i == 0) begin
        total++;
        if (period_start !== 1'b1) $display("FAIL first_period_start got %b want 1", period_start); else pass_cnt++;
      end
      total++;
      if (obs() !== exp_vec()) $display("FAIL reset_release cyc%0d got %b want %b", i, obs(), exp_vec()); else pass_cnt++;
    end
  endtask

  task automatic test_basic();
    int on_cnt, ps_cnt;
    enable = 1'b1;
    drive_cmd(1'b1, 3);
    for (int i = 0; i < 2 * P; i++) begin
      tick(); total++;
      if (obs() !== exp_vec()) $display("FAIL basic_settle cyc%0d got %b want %b", i, obs(), exp_vec()); else pass_cnt++;
    end
    on_cnt = 0; ps_cnt = 0;
    for (int i = 0; i < 2 * P; i++) begin
      tick(); total++;
      if (obs() !== exp_vec()) $display("FAIL basic_run cyc%0d got %b want %b", i, obs(), exp_vec()); else pass_cnt++;
      on_cnt += int'(on); ps_cnt += int'(period_start);
    end
    total++;
    if (on_cnt != 6 || ps_cnt != 2 || dir !== 1'b1)
      $display("FAIL basic_counts got on=%0d ps=%0d dir=%b want on=6 ps=2 dir=1", on_cnt, ps_cnt, dir);
    else pass_cnt++;
  endtask

  task automatic test_clamp();
    drive_cmd(1'b1, 12);
    for (int i = 0; i < 2 * P; i++) begin
      tick(); total++;
      if (obs() !== exp_vec()) $display("FAIL clamp_settle cyc%0d got %b want %b", i, obs(), exp_vec()); else pass_cnt++;
    end
    for (int i = 0; i < P; i++) begin
      tick(); total++;
      if (on !== 1'b1 || obs() !== exp_vec()) $display("FAIL clamp_full cyc%0d got %b want %b", i, obs(), exp_vec()); else pass_cnt++;
    end
    drive_cmd(1'b1, 0);
    for (int i = 0; i < 2 * P; i++) begin
      tick(); total++;
      if (obs() !== exp_vec()) $display("FAIL clamp_zero cyc%0d got %b want %b", i, obs(), exp_vec()); else pass_cnt++;
    end
    for (int i = 0; i < P; i++) begin
      tick(); total++;
      if (on !== 1'b0) $display("FAIL zero_duty_off cyc%0d got on=%b want 0", i, on); else pass_cnt++;
    end
  endtask

  task automatic test_reverse();
    int rev_cnt; bit dir_bad;
    drive_cmd(1'b0, 5);
    for (int i = 0; i < 2 * P; i++) begin
      tick(); total++;
      if (obs() !== exp_vec()) $display("FAIL rev_prep cyc%0d got %b want %b", i, obs(), exp_vec()); else pass_cnt++;
    end
    drive_cmd(1'b1, 5);
    rev_cnt = 0; dir_bad = 0;
    for (int i = 0; i < 4 * P; i++) begin
      tick(); total++;
      if (obs() !== exp_vec()) $display("FAIL rev_run cyc%0d got %b want %b", i, obs(), exp_vec()); else pass_cnt++;
      if (reversing) begin
        rev_cnt++;
        if (dir !== 1'b0 || on !== 1'b0) dir_bad = 1;
      end
    end
    total++;
    if (rev_cnt != G || dir_bad || dir !== 1'b1)
      $display("FAIL rev_gap got rev=%0d bad=%0d dir=%b want rev=%0d bad=0 dir=1", rev_cnt, dir_bad, dir, G);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int on_a, on_b;
    drive_cmd(1'b1, 6);
    bus.cmd_valid = 1'b1; bus.cmd_dir = 1'b1; bus.cmd_duty = 10'd6;
    total++;
    if (bus.cmd_ready !== 1'b0) $display("FAIL b2b_stall got ready=%b want 0", bus.cmd_ready); else pass_cnt++;
    drive_cmd(1'b1, 6);
    for (int i = 0; i < 2 * P; i++) begin
      tick(); total++;
      if (obs() !== exp_vec()) $display("FAIL b2b_run cyc%0d got %b want %b", i, obs(), exp_vec()); else pass_cnt++;
    end
    for (int i = 0; i < P && (t % P) != P - 1; i++) begin
      tick(); total++;
      if (obs() !== exp_vec()) $display("FAIL b2b_align cyc%0d got %b want %b", i, obs(), exp_vec()); else pass_cnt++;
    end
    bus.cmd_valid = 1'b1; bus.cmd_dir = 1'b1; bus.cmd_duty = 10'd1;
    m_accepted = 0;
    tick();
    bus.cmd_valid = 1'b0;
    total++;
    if (!m_accepted || obs() !== exp_vec()) $display("FAIL boundary_accept got %b want %b", obs(), exp_vec()); else pass_cnt++;
    on_a = 0; on_b = 0;
    for (int i = 0; i < 2 * P; i++) begin
      tick(); total++;
      if (obs() !== exp_vec()) $display("FAIL boundary_hold cyc%0d got %b want %b", i, obs(), exp_vec()); else pass_cnt++;
      if (i < P) on_a += int'(on); else on_b += int'(on);
    end
    total++;
    if (on_a != 6 || on_b != 1) $display("FAIL boundary_delay got on=%0d,%0d want 6,1", on_a, on_b); else pass_cnt++;
  endtask

  task automatic test_enable();
    bit seen;
    drive_cmd(1'b1, 5);
    seen = 0;
    for (int i = 0; i < 3 * P && !seen; i++) begin
      tick(); total++;
      if (obs() !== exp_vec()) $display("FAIL en_prep cyc%0d got %b want %b", i, obs(), exp_vec()); else pass_cnt++;
      seen = on;
    end
    enable = 1'b0;
    tick(); total++;
    if (!seen || on !== 1'b0 || obs() !== exp_vec())
      $display("FAIL en_kill got on=%b seen=%0d vec=%b want on=0 vec=%b", on, seen, obs(), exp_vec());
    else pass_cnt++;
    drive_cmd(1'b0, 4);
    for (int i = 0; i < 2 * P; i++) begin
      tick(); total++;
      if (on !== 1'b0 || obs() !== exp_vec()) $display("FAIL en_off cyc%0d got %b want %b", i, obs(), exp_vec()); else pass_cnt++;
    end
    enable = 1'b1;
    drive_cmd(1'b1, 4);
    for (int i = 0; i < 3 * P; i++) begin
      tick(); total++;
      if (obs() !== exp_vec()) $display("FAIL en_resume cyc%0d got %b want %b", i, obs(), exp_vec()); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_rev();
    bit in_rev;
    drive_cmd(1'b0, 4);
    in_rev = 0;
    for (int i = 0; i < 3 * P && !in_rev; i++) begin
      tick(); total++;
      if (obs() !== exp_vec()) $display("FAIL rst_rev_prep cyc%0d got %b want %b", i, obs(), exp_vec()); else pass_cnt++;
      in_rev = reversing;
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (!in_rev || obs() !== 5'b00001) $display("FAIL async_reset got %b rev_seen=%0d want 00001", obs(), in_rev); else pass_cnt++;
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2 * P; i++) begin
      tick(); total++;
      if (on !== 1'b0 || obs() !== exp_vec()) $display("FAIL rst_rev_after cyc%0d got %b want %b", i, obs(), exp_vec()); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (!bus.cmd_valid && $urandom_range(0, 5) == 0) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = 1'($urandom_range(0, 1));
        bus.cmd_duty  = 10'($urandom_range(0, 12));
        m_accepted    = 0;
      end
      enable = ($urandom_range(0, 24) != 0);
      tick(); total++;
      if (obs() !== exp_vec()) $display("FAIL random cyc%0d got %b want %b", i, obs(), exp_vec()); else pass_cnt++;
      if (bus.cmd_valid && m_accepted) bus.cmd_valid = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_reverse();
    test_back_to_back();
    test_enable();
    test_reset_mid_rev();
    enable = 1'b1;
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end
endmodule
